// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU select codes, FSM states, datapath width.
`default_nettype none

package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_flag_gen.sv
// Combinational carry/zero flags derived from the held ALU operands, select code and ALU result.
`default_nettype none

module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] alu_a_i,
  input  logic [WIDTH-1:0] alu_b_i,
  input  logic [2:0]       alu_sel_i,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             carry_o,
  output logic             zero_o
);

  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;

  // The extra top bit is carry-out for add and borrow (a < b unsigned) for sub.
  assign sum_w  = {1'b0, alu_a_i} + {1'b0, alu_b_i};
  assign diff_w = {1'b0, alu_a_i} - {1'b0, alu_b_i};

  always_comb begin
    carry_o = 1'b0;
    if (alu_sel_i == OP_ADD) begin
      carry_o = sum_w[WIDTH];
    end else if (alu_sel_i == OP_SUB) begin
      carry_o = diff_w[WIDTH];
    end
  end

  assign zero_o = (alu_result_i == '0);

endmodule : alu_flag_gen

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// Issue stage for the 4-bit combinational ALU: holds operands/select stable, captures the
// result one cycle later with carry/zero flags, and keeps an accumulator for chained ops.
`default_nettype none

module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       in_op_i,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic             in_use_acc_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_sel_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_result_o,
  output logic             out_carry_o,
  output logic             out_zero_o,
  output logic [WIDTH-1:0] acc_o
);

  state_t           state_q;
  logic             in_ready_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_sel_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic             out_carry_q;
  logic             out_zero_q;
  logic [WIDTH-1:0] acc_q;

  logic             carry_d;
  logic             zero_d;

  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .alu_a_i      (alu_a_q),
    .alu_b_i      (alu_b_q),
    .alu_sel_i    (alu_sel_q),
    .alu_result_i (alu_result_i),
    .carry_o      (carry_d),
    .zero_o       (zero_d)
  );

  // in_ready is registered, so the first IDLE cycle after reset release still reports 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= OP_ADD;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      acc_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_ready_q && in_valid_i) begin
            // Operands and select move together so the ALU never sees a lone select change.
            alu_a_q    <= in_use_acc_i ? acc_q : in_a_i;
            alu_b_q    <= in_b_i;
            alu_sel_q  <= in_op_i;
            in_ready_q <= 1'b0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          out_result_q <= alu_result_i;
          acc_q        <= alu_result_i;
          out_carry_q  <= carry_d;
          out_zero_q   <= zero_d;
          out_valid_q  <= 1'b1;
          state_q      <= HOLD;
        end
        HOLD: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_sel_o    = alu_sel_q;
  assign out_valid_o  = out_valid_q;
  assign out_result_o = out_result_q;
  assign out_carry_o  = out_carry_q;
  assign out_zero_o   = out_zero_q;
  assign acc_o        = acc_q;

endmodule : alu_issue_stage

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural ALU and an operation-level reference model.
`default_nettype none

module tb_alu_issue_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_use_acc;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_result;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_carry;
  logic       out_zero;
  logic [3:0] acc;

  int vectors;
  int miscompares;
  int m_acc;

  alu_issue_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_op_i      (in_op),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .in_use_acc_i (in_use_acc),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_sel_o    (alu_sel),
    .alu_result_i (alu_result),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_carry_o  (out_carry),
    .out_zero_o   (out_zero),
    .acc_o        (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operation semantics on plain integers 0..15: returns result, sets carry/borrow.
  function automatic int ref_op(input int op, input int a, input int b, output int cy);
    int r;
    cy = 0;
    case (op)
      0: begin r = a + b; cy = (r > 15) ? 1 : 0; end
      1: begin r = a - b; cy = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - (a ^ b);
      6: r = 15 - a;
      default: r = a;
    endcase
    return ((r % 16) + 16) % 16;
  endfunction

  // Stand-in for the external combinational ALU sitting beside the stage.
  int alu_cy_unused;
  always_comb begin
    alu_result = 4'(ref_op(int'(alu_sel), int'(alu_a), int'(alu_b), alu_cy_unused));
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One full operation: accept, EXEC, optional backpressure in HOLD, handshake back to IDLE.
  task automatic run_op(input int op, input int a, input int b, input bit use_acc, input int stall);
    int opa, res, cy, zr, waited;
    opa = use_acc ? m_acc : a;
    res = ref_op(op, opa, b, cy);
    zr  = (res == 0) ? 1 : 0;

    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_wait", {7'd0, in_ready}, 8'd1);
    in_op = 3'(op); in_a = 4'(a); in_b = 4'(b); in_use_acc = use_acc;
    in_valid = 1'b1;
    out_ready = (stall == 0);

    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("exec_alu_a", 8'(alu_a), 8'(opa));
    chk("exec_alu_b", 8'(alu_b), 8'(b));
    chk("exec_alu_sel", 8'(alu_sel), 8'(op));
    chk("exec_in_ready", {7'd0, in_ready}, 8'd0);
    chk("exec_out_valid", {7'd0, out_valid}, 8'd0);

    @(posedge clk); #1;
    m_acc = res;
    chk("hold_valid", {7'd0, out_valid}, 8'd1);
    chk("hold_result", 8'(out_result), 8'(res));
    chk("hold_carry", {7'd0, out_carry}, 8'(cy));
    chk("hold_zero", {7'd0, out_zero}, 8'(zr));
    chk("hold_acc", 8'(acc), 8'(res));

    for (int i = 0; i < stall; i++) begin
      in_valid = (i < stall - 1);
      in_a = 4'(~a); in_b = 4'(~b); in_op = 3'(op + 1);
      @(posedge clk); #1;
      chk("stall_valid", {7'd0, out_valid}, 8'd1);
      chk("stall_result", 8'(out_result), 8'(res));
      chk("stall_in_ready", {7'd0, in_ready}, 8'd0);
      chk("stall_alu_a", 8'(alu_a), 8'(opa));
      chk("stall_alu_sel", 8'(alu_sel), 8'(op));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (stall > 0) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("done_valid", {7'd0, out_valid}, 8'd0);
    chk("done_in_ready", {7'd0, in_ready}, 8'd1);
    chk("done_alu_a_held", 8'(alu_a), 8'(opa));
  endtask

  initial begin
    vectors = 0; miscompares = 0; m_acc = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 3'd0; in_a = 4'd0; in_b = 4'd0; in_use_acc = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_acc", 8'(acc), 8'd0);
    chk("rst_alu_a", 8'(alu_a), 8'd0);
    chk("rst_alu_sel", 8'(alu_sel), 8'd0);
    chk("rst_out_result", 8'(out_result), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;  // asserted before any out_valid: must be harmless
    @(posedge clk); #1;
    chk("post_rst_out_valid", {7'd0, out_valid}, 8'd0);

    // Directed cases from the plan.
    run_op(0, 9, 8, 1'b0, 0);
    run_op(1, 3, 5, 1'b0, 0);
    run_op(1, 5, 5, 1'b0, 0);
    run_op(0, 2, 3, 1'b0, 0);
    run_op(0, 15, 4, 1'b1, 0);
    run_op(3, 6, 9, 1'b0, 5);
    for (int op = 0; op < 8; op++) run_op(op, 10, 6, 1'b0, 0);

    // Reset while EXEC: in-flight op is dropped.
    @(negedge clk);
    in_op = 3'd0; in_a = 4'd7; in_b = 4'd7; in_use_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("midrst_acc", 8'(acc), 8'd0);
    chk("midrst_in_ready", {7'd0, in_ready}, 8'd0);
    chk("midrst_alu_a", 8'(alu_a), 8'd0);
    m_acc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_in_ready", {7'd0, in_ready}, 8'd1);
    chk("after_rst_no_stale", {7'd0, out_valid}, 8'd0);
    @(posedge clk); #1;
    chk("after_rst_no_stale2", {7'd0, out_valid}, 8'd0);

    // Randomized operations, including accumulator chaining and backpressure.
    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_alu_issue_stage

`default_nettype wire
